// File: rtl/pf_ddr3_addr_dly_ctrl_if.sv
// rtl/pf_ddr3_addr_dly_ctrl_if.sv - command and delay-line bundle for the address/command lane delay controller
interface pf_ddr3_addr_dly_ctrl_if #(
   parameter int NUM_LANES = 16,
   parameter int TAP_W     = 8,
   parameter int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
);
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [LANE_W-1:0]    cmd_lane;
   logic [TAP_W-1:0]     cmd_target;
   logic                 cmd_load;
   logic                 done;
   logic                 err;
   logic [TAP_W-1:0]     stat_tap;
   logic [NUM_LANES-1:0] delay_line_move;
   logic [NUM_LANES-1:0] delay_line_direction;
   logic [NUM_LANES-1:0] delay_line_load;
   logic [NUM_LANES-1:0] delay_line_out_of_range;

   // calibration sequencer / IOD side
   modport master (
      output cmd_valid, cmd_lane, cmd_target, cmd_load, delay_line_out_of_range,
      input  cmd_ready, done, err, stat_tap,
             delay_line_move, delay_line_direction, delay_line_load
   );

   // controller side
   modport slave (
      input  cmd_valid, cmd_lane, cmd_target, cmd_load, delay_line_out_of_range,
      output cmd_ready, done, err, stat_tap,
             delay_line_move, delay_line_direction, delay_line_load
   );
endinterface

// File: rtl/pf_ddr3_addr_dly_ctrl.sv
// rtl/pf_ddr3_addr_dly_ctrl.sv - turns tap-target commands into per-lane IOD load/move/direction pulses
module pf_ddr3_addr_dly_ctrl #(
   parameter int NUM_LANES  = 16,
   parameter int TAP_W      = 8,
   parameter int INIT_TAP   = 1,
   parameter int SETTLE_CYC = 4,
   parameter int LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
   input logic                    fab_clk,
   input logic                    arst_n,
   pf_ddr3_addr_dly_ctrl_if.slave bus
);
   localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_COMPARE, S_STEP, S_SETTLE, S_DONE, S_ERROR
   } state_t;

   state_t               state_q, state_d;
   logic [TAP_W-1:0]     tap [NUM_LANES];
   logic [LANE_W-1:0]    lane_q, lane_d;
   logic [TAP_W-1:0]     target_q, target_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 from_step_q, from_step_d;
   logic                 tap_we;
   logic [TAP_W-1:0]     tap_wd;
   logic [TAP_W-1:0]     tap_cur;
   logic                 lane_bad;
   logic                 settle_last;
   logic                 oor_hit;
   logic [NUM_LANES-1:0] move_q, move_d;
   logic [NUM_LANES-1:0] load_q, load_d;
   logic [NUM_LANES-1:0] dir_q, dir_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic [TAP_W-1:0]     stat_q, stat_d;

   assign tap_cur     = tap[lane_q];
   assign lane_bad    = int'(bus.cmd_lane) >= NUM_LANES;
   assign settle_last = (cnt_q == CNT_W'(SETTLE_CYC - 1));
   // only a step can push the line past its end; a failed load settle is ignored
   assign oor_hit     = from_step_q && bus.delay_line_out_of_range[lane_q];

   assign bus.cmd_ready            = (state_q == S_IDLE);
   assign bus.done                 = done_q;
   assign bus.err                  = err_q;
   assign bus.stat_tap             = stat_q;
   assign bus.delay_line_move      = move_q;
   assign bus.delay_line_load      = load_q;
   assign bus.delay_line_direction = dir_q;

   // state register
   always_ff @(posedge fab_clk or negedge arst_n) begin
      if (!arst_n) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // next-state decode
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               if (lane_bad)          state_d = S_ERROR;
               else if (bus.cmd_load) state_d = S_LOAD;
               else                   state_d = S_COMPARE;
            end
         end
         S_LOAD:    state_d = S_SETTLE;
         S_COMPARE: state_d = (tap_cur == target_q) ? S_DONE : S_STEP;
         S_STEP:    state_d = S_SETTLE;
         S_SETTLE: begin
            if (settle_last) state_d = oor_hit ? S_ERROR : S_COMPARE;
         end
         S_DONE:    state_d = S_IDLE;
         S_ERROR:   state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // datapath and next output values; pulses are decoded from the next state so they register cleanly
   always_comb begin
      lane_d      = lane_q;
      target_d    = target_q;
      cnt_d       = '0;
      from_step_d = from_step_q;
      tap_we      = 1'b0;
      tap_wd      = tap_cur;
      move_d      = '0;
      load_d      = '0;
      dir_d       = dir_q;

      if (state_q == S_IDLE && bus.cmd_valid && !lane_bad) begin
         lane_d   = bus.cmd_lane;
         target_d = bus.cmd_target;
      end
      if (state_q == S_SETTLE && !settle_last) cnt_d = cnt_q + CNT_W'(1);
      if (state_q == S_LOAD) begin
         tap_we      = 1'b1;
         tap_wd      = TAP_W'(INIT_TAP);
         from_step_d = 1'b0;
      end
      if (state_q == S_STEP) begin
         tap_we      = 1'b1;
         tap_wd      = dir_q[lane_q] ? tap_cur + TAP_W'(1) : tap_cur - TAP_W'(1);
         from_step_d = 1'b1;
      end
      if (state_q == S_SETTLE && settle_last && oor_hit) begin
         tap_we = 1'b1;
         tap_wd = dir_q[lane_q] ? tap_cur - TAP_W'(1) : tap_cur + TAP_W'(1);
      end

      if (state_d == S_STEP) move_d[lane_q] = 1'b1;
      if (state_d == S_LOAD) load_d[lane_d] = 1'b1;
      // direction settles on entry to COMPARE, one cycle ahead of any move
      if (state_d == S_COMPARE && target_d != tap[lane_d])
         dir_d[lane_d] = (target_d > tap[lane_d]);

      done_d = (state_d == S_DONE);
      err_d  = (state_d == S_ERROR);
      stat_d = tap_we ? tap_wd : tap[lane_d];
   end

   // per-lane tap tracking
   always_ff @(posedge fab_clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < NUM_LANES; i++) tap[i] <= TAP_W'(INIT_TAP);
      end else if (tap_we) begin
         tap[lane_q] <= tap_wd;
      end
   end

   // command latches, settle counter and registered outputs
   always_ff @(posedge fab_clk or negedge arst_n) begin
      if (!arst_n) begin
         lane_q      <= '0;
         target_q    <= '0;
         cnt_q       <= '0;
         from_step_q <= 1'b0;
         move_q      <= '0;
         load_q      <= '0;
         dir_q       <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         stat_q      <= TAP_W'(INIT_TAP);
      end else begin
         lane_q      <= lane_d;
         target_q    <= target_d;
         cnt_q       <= cnt_d;
         from_step_q <= from_step_d;
         move_q      <= move_d;
         load_q      <= load_d;
         dir_q       <= dir_d;
         done_q      <= done_d;
         err_q       <= err_d;
         stat_q      <= stat_d;
      end
   end
endmodule
